conv_sched: RTL and testbench

Sequencing controller for the RepVGG conv datapath (pe3x3/pe1x1 array plus accumulator). On a start pulse it walks every output channel, every input channel and every fmap column. For each step it requests the weight set, issues feature-map RAM reads, drives per-column PE padding configuration and accumulator enables, and then streams the finished output channel to the write-back path under a valid/ready handshake.

---
 rtl/conv_sched_if.sv | 42 ++++
 rtl/conv_sched.sv | 160 ++++++++++++++++
 tb/tb_conv_sched.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sched_if.sv
// conv_sched_if: control/handshake bundle between conv_sched and the conv datapath.
// master = sequencer (drives strobes/indices), slave = datapath + write-back side.
// Widths of column/channel indices follow the layer geometry parameters.
interface conv_sched_if #(
  parameter int HIT    = 56,
  parameter int CH_IN  = 64,
  parameter int CH_OUT = 64,
  parameter int AW     = 12
) ();
  localparam int CW = (HIT > 1) ? $clog2(HIT) : 1;
  localparam int IW = (CH_IN > 1) ? $clog2(CH_IN) : 1;
  localparam int OW = (CH_OUT > 1) ? $clog2(CH_OUT) : 1;

  logic          start;
  logic          busy;
  logic          done;
  logic          wht_req;
  logic          wht_valid;
  logic          fmap_cs;
  logic [AW-1:0] fmap_addr;
  logic          pe_en;
  logic [1:0]    pe_cfg;
  logic          acc_clr;
  logic          acc_en;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_col;
  logic [OW-1:0] co_idx;
  logic [IW-1:0] ci_idx;

  modport master (
    input  start, wht_valid, out_ready,
    output busy, done, wht_req, fmap_cs, fmap_addr, pe_en, pe_cfg,
           acc_clr, acc_en, out_valid, out_col, co_idx, ci_idx
  );

  modport slave (
    output start, wht_valid, out_ready,
    input  busy, done, wht_req, fmap_cs, fmap_addr, pe_en, pe_cfg,
           acc_clr, acc_en, out_valid, out_col, co_idx, ci_idx
  );
endinterface

// File: rtl/conv_sched.sv
// conv_sched: walks co -> ci -> col, requests weights, reads fmap, drives PE/acc strobes.
// Latency: WLOAD 1+ cycle, RUN HIT cycles, DRAIN LAT+1 cycles per ci; pe_en +1, acc_en +1+LAT.
// Backpressure: WLOAD holds on wht_valid=0; WRITE holds out_col stable while out_ready=0.
module conv_sched #(
  parameter int HIT    = 56,
  parameter int CH_IN  = 64,
  parameter int CH_OUT = 64,
  parameter int AW     = 12,
  parameter int LAT    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  conv_sched_if.master sif
);
  localparam int CW = (HIT > 1) ? $clog2(HIT) : 1;
  localparam int IW = (CH_IN > 1) ? $clog2(CH_IN) : 1;
  localparam int OW = (CH_OUT > 1) ? $clog2(CH_OUT) : 1;
  localparam int DW = $clog2(LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_RUN, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   co_q, co_d;
  logic [IW-1:0]   ci_q, ci_d;
  logic [CW-1:0]   col_q, col_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            wl_wait_q, wl_wait_d;   // already spent >=1 cycle in this WLOAD
  logic            pe_en_q, pe_en_d;
  logic [1:0]      pe_cfg_q, pe_cfg_d;
  logic [LAT-1:0]  acc_pipe_q;

  // Next-state, counter updates and all combinational outputs
  always_comb begin
    state_d   = state_q;
    co_d      = co_q;
    ci_d      = ci_q;
    col_d     = col_q;
    dcnt_d    = dcnt_q;
    pe_en_d   = 1'b0;
    pe_cfg_d  = 2'd0;
    sif.busy      = (state_q != S_IDLE);
    sif.done      = 1'b0;
    sif.wht_req   = 1'b0;
    sif.acc_clr   = 1'b0;
    sif.fmap_cs   = 1'b0;
    sif.fmap_addr = '0;
    sif.out_valid = 1'b0;
    sif.out_col   = '0;
    sif.co_idx    = '0;
    sif.ci_idx    = '0;
    if (state_q != S_IDLE) begin
      sif.co_idx = co_q;
      sif.ci_idx = ci_q;
    end

    case (state_q)
      S_IDLE: begin
        if (sif.start) begin
          co_d    = '0;
          ci_d    = '0;
          state_d = S_WLOAD;
        end
      end
      S_WLOAD: begin
        sif.wht_req = 1'b1;
        // accumulator cleared once per output channel, on entry only
        sif.acc_clr = (ci_q == '0) && !wl_wait_q;
        if (sif.wht_valid) begin
          col_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sif.fmap_cs   = 1'b1;
        sif.fmap_addr = AW'(ci_q) * AW'(HIT) + AW'(col_q);
        pe_en_d       = 1'b1;
        // left pad wins when a channel is a single column wide
        if (col_q == '0)                pe_cfg_d = 2'd1;
        else if (col_q == CW'(HIT - 1)) pe_cfg_d = 2'd2;
        if (col_q == CW'(HIT - 1)) begin
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_DRAIN: begin
        // wait out the RAM + PE pipeline so acc_en finishes before the next acc_clr
        if (dcnt_q == DW'(LAT)) begin
          if (ci_q != IW'(CH_IN - 1)) begin
            ci_d    = ci_q + IW'(1);
            state_d = S_WLOAD;
          end else begin
            ci_d    = '0;
            col_d   = '0;
            state_d = S_WRITE;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_WRITE: begin
        sif.out_valid = 1'b1;
        sif.out_col   = col_q;
        if (sif.out_ready) begin
          if (col_q == CW'(HIT - 1)) begin
            col_d = '0;
            if (co_q != OW'(CH_OUT - 1)) begin
              co_d    = co_q + OW'(1);
              state_d = S_WLOAD;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        sif.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wl_wait_d = (state_q == S_WLOAD) && (state_d == S_WLOAD);
  end

  assign sif.pe_en  = pe_en_q;
  assign sif.pe_cfg = pe_cfg_q;
  assign sif.acc_en = acc_pipe_q[LAT-1];

  // State, counters and the fmap->PE->accumulator delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      co_q       <= '0;
      ci_q       <= '0;
      col_q      <= '0;
      dcnt_q     <= '0;
      wl_wait_q  <= 1'b0;
      pe_en_q    <= 1'b0;
      pe_cfg_q   <= 2'd0;
      acc_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      co_q          <= co_d;
      ci_q          <= ci_d;
      col_q         <= col_d;
      dcnt_q        <= dcnt_d;
      wl_wait_q     <= wl_wait_d;
      pe_en_q       <= pe_en_d;
      pe_cfg_q      <= pe_cfg_d;
      acc_pipe_q[0] <= pe_en_q;
      for (int i = 1; i < LAT; i++) acc_pipe_q[i] <= acc_pipe_q[i-1];
    end
  end
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: loop-nest reference schedule compared against conv_sched every cycle.
// Stimulus: tied, delayed, toggled and random wht_valid/out_ready; mid-layer async reset.
// Literal pins on address/pad sequences, clear count, stall length and done timing.
module tb_conv_sched;
  localparam int HIT = 4, CH_IN = 2, CH_OUT = 2, AW = 4, LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_sched_if #(.HIT(HIT), .CH_IN(CH_IN), .CH_OUT(CH_OUT), .AW(AW)) sif ();

  conv_sched #(.HIT(HIT), .CH_IN(CH_IN), .CH_OUT(CH_OUT), .AW(AW), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif.master)
  );

  int checks = 0;
  int failures = 0;

  // input driver: 0 tied high, 1 random, 2 stall (wht) / toggle 1,0,0 (ready)
  int wmode = 0, rmode = 0, wreq_run = 0, tcnt = 0;
  always @(posedge clk) begin
    #1;
    tcnt++;
    if (sif.wht_req) wreq_run++; else wreq_run = 0;
    case (wmode)
      0:       sif.wht_valid = 1'b1;
      1:       sif.wht_valid = ($urandom_range(0, 2) == 0);
      default: sif.wht_valid = (sif.ci_idx != 1) || (wreq_run >= 6);
    endcase
    case (rmode)
      0:       sif.out_ready = 1'b1;
      1:       sif.out_ready = 1'($urandom_range(0, 1));
      default: sif.out_ready = (tcnt % 3 == 0);
    endcase
  end

  // expected values for the current cycle
  bit e_busy, e_done, e_wreq, e_clr, e_cs, e_ov;
  int e_addr, e_fcol, e_ocol, e_co, e_ci;
  bit h_cs[LAT+1];     // expected fmap_cs, index 0 = one cycle ago
  int h_col[LAT+1];
  bit s_wv, s_rdy;
  int lcyc = 0, poke_at = -1;

  // observations of the DUT used for literal pins
  int m_cyc, m_rise, m_done_at, m_dones, m_clr, m_wrun, m_wmax, m_beats;
  int m_colseen[HIT];
  int m_addr[$];
  int m_cfg[$];
  bit m_pbusy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic bail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at t=%0t", nm, $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [1:0] cfg_of(input int c);
    if (c == 0) return 2'd1;
    if (c == HIT - 1) return 2'd2;
    return 2'd0;
  endfunction

  task automatic clr_stats();
    m_cyc = 0; m_rise = 0; m_done_at = 0; m_dones = 0; m_clr = 0;
    m_wrun = 0; m_wmax = 0; m_beats = 0;
    foreach (m_colseen[i]) m_colseen[i] = 0;
    m_addr.delete();
    m_cfg.delete();
  endtask

  task automatic ex(input bit busy, done, wreq, clr, cs, input int fcol,
                    input bit ov, input int ocol, co, ci);
    e_busy = busy; e_done = done; e_wreq = wreq; e_clr = clr; e_cs = cs;
    e_fcol = fcol; e_ov = ov; e_ocol = ocol; e_co = co; e_ci = ci;
    e_addr = cs ? ci * HIT + fcol : 0;
  endtask

  task automatic ex_idle();
    ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // one clock: compare every output against the reference, then log observations
  task automatic cyc();
    @(negedge clk);
    chk("busy", sif.busy, e_busy);
    chk("done", sif.done, e_done);
    chk("wht_req", sif.wht_req, e_wreq);
    chk("fmap_cs", sif.fmap_cs, e_cs);
    chk("fmap_addr", sif.fmap_addr, e_addr);
    chk("pe_en", sif.pe_en, h_cs[0]);
    chk("pe_cfg", sif.pe_cfg, h_cs[0] ? cfg_of(h_col[0]) : 2'd0);
    chk("acc_clr", sif.acc_clr, e_clr);
    chk("acc_en", sif.acc_en, h_cs[LAT]);
    chk("out_valid", sif.out_valid, e_ov);
    chk("out_col", sif.out_col, e_ocol);
    chk("co_idx", sif.co_idx, e_co);
    chk("ci_idx", sif.ci_idx, e_ci);
    s_wv = sif.wht_valid;
    s_rdy = sif.out_ready;
    for (int i = LAT; i > 0; i--) begin
      h_cs[i] = h_cs[i-1];
      h_col[i] = h_col[i-1];
    end
    h_cs[0] = e_cs;
    h_col[0] = e_fcol;
    m_cyc++;
    if (sif.busy && !m_pbusy) m_rise = m_cyc;
    m_pbusy = sif.busy;
    if (sif.done) begin m_dones++; m_done_at = m_cyc; end
    if (sif.acc_clr) m_clr++;
    if (sif.wht_req) begin
      m_wrun++;
      if (m_wrun > m_wmax) m_wmax = m_wrun;
    end else m_wrun = 0;
    if (sif.fmap_cs) m_addr.push_back(int'(sif.fmap_addr));
    if (sif.pe_en) m_cfg.push_back(int'(sif.pe_cfg));
    if (sif.out_valid && sif.out_ready) begin
      m_beats++;
      m_colseen[sif.out_col]++;
    end
    sif.start = (lcyc == poke_at);
    lcyc++;
  endtask

  // reference schedule: a plain loop nest over co, ci, col
  task automatic run_layer(input int ab_ci, input int ab_col, output bit aborted);
    int n;
    aborted = 0;
    for (int co = 0; co < CH_OUT; co++) begin
      for (int ci = 0; ci < CH_IN; ci++) begin
        n = 0;
        do begin
          ex(1, 0, 1, (ci == 0 && n == 0), 0, 0, 0, 0, co, ci);
          cyc();
          n++;
          if (n > 64) begin bail("wht_wait"); return; end
        end while (!s_wv);
        for (int col = 0; col < HIT; col++) begin
          if (co == 0 && ci == ab_ci && col == ab_col) begin aborted = 1; return; end
          ex(1, 0, 0, 0, 1, col, 0, 0, co, ci);
          cyc();
        end
        for (int d = 0; d <= LAT; d++) begin
          ex(1, 0, 0, 0, 0, 0, 0, 0, co, ci);
          cyc();
        end
      end
      for (int col = 0; col < HIT; col++) begin
        n = 0;
        do begin
          ex(1, 0, 0, 0, 0, 0, 1, col, co, 0);
          cyc();
          n++;
          if (n > 64) begin bail("out_wait"); return; end
        end while (!s_rdy);
      end
    end
    ex(1, 1, 0, 0, 0, 0, 0, 0, CH_OUT - 1, 0);
    cyc();
  endtask

  task automatic start_layer();
    ex_idle();
    cyc();
    sif.start = 1'b1;
    lcyc = 0;
  endtask

  task automatic idle_cycles(input int n);
    ex_idle();
    repeat (n) cyc();
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_busy"}, sif.busy, 0);
    chk({tag, "_done"}, sif.done, 0);
    chk({tag, "_wreq"}, sif.wht_req, 0);
    chk({tag, "_cs"}, sif.fmap_cs, 0);
    chk({tag, "_addr"}, sif.fmap_addr, 0);
    chk({tag, "_pe_en"}, sif.pe_en, 0);
    chk({tag, "_pe_cfg"}, sif.pe_cfg, 0);
    chk({tag, "_clr"}, sif.acc_clr, 0);
    chk({tag, "_acc_en"}, sif.acc_en, 0);
    chk({tag, "_ov"}, sif.out_valid, 0);
    chk({tag, "_co"}, sif.co_idx, 0);
    chk({tag, "_ci"}, sif.ci_idx, 0);
  endtask

  task automatic reset_model();
    for (int i = 0; i <= LAT; i++) begin h_cs[i] = 0; h_col[i] = 0; end
    m_pbusy = 0;
    ex_idle();
  endtask

  task automatic chk_seq_pins(input string tag);
    int cfg_pat[4];
    cfg_pat = '{1, 0, 0, 2};
    chk({tag, "_n_addr"}, m_addr.size(), CH_OUT * CH_IN * HIT);
    for (int i = 0; i < m_addr.size() && i < 16; i++)
      chk({tag, "_addr_seq"}, m_addr[i], i % 8);
    chk({tag, "_n_cfg"}, m_cfg.size(), CH_OUT * CH_IN * HIT);
    for (int i = 0; i < m_cfg.size() && i < 16; i++)
      chk({tag, "_cfg_seq"}, m_cfg[i], cfg_pat[i % 4]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit at t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit ab;
    sif.start = 1'b0;
    sif.wht_valid = 1'b1;
    sif.out_ready = 1'b1;
    reset_model();
    clr_stats();
    #1;
    zero_chk("in_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // idle after reset, no start
    idle_cycles(20);

    // minimal layer, zero-wait, with a start poked while busy
    clr_stats();
    wmode = 0; rmode = 0;
    poke_at = 10;
    start_layer();
    run_layer(-1, -1, ab);
    poke_at = -1;
    idle_cycles(5);
    chk_seq_pins("min");
    chk("min_acc_clr_count", m_clr, 2);
    chk("min_beats", m_beats, 8);
    chk("min_done_count", m_dones, 1);
    chk("min_done_cycle", m_done_at - m_rise + 1, 41);

    // weight stall on ci=1
    clr_stats();
    wmode = 2;
    start_layer();
    run_layer(-1, -1, ab);
    idle_cycles(3);
    chk("stall_wreq_len", m_wmax, 6);
    chk_seq_pins("stall");
    chk("stall_done_count", m_dones, 1);

    // write-back backpressure 1,0,0 pattern
    clr_stats();
    wmode = 0; rmode = 2;
    start_layer();
    run_layer(-1, -1, ab);
    idle_cycles(3);
    chk("bp_beats", m_beats, 8);
    for (int c = 0; c < HIT; c++) chk("bp_col_seen", m_colseen[c], CH_OUT);

    // random handshakes, two layers
    wmode = 1; rmode = 1;
    for (int k = 0; k < 2; k++) begin
      clr_stats();
      start_layer();
      run_layer(-1, -1, ab);
      idle_cycles(2);
      chk("rnd_done_count", m_dones, 1);
      chk("rnd_beats", m_beats, 8);
    end

    // async reset in RUN at ci=1, col=2
    wmode = 0; rmode = 0;
    clr_stats();
    start_layer();
    run_layer(1, 2, ab);
    chk("abort_reached", ab, 1);
    @(posedge clk);
    #1;
    chk("pre_rst_cs", sif.fmap_cs, 1);
    chk("pre_rst_addr", sif.fmap_addr, 6);
    rst_n = 1'b0;
    #1;
    zero_chk("mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    clr_stats();
    idle_cycles(3);
    start_layer();
    run_layer(-1, -1, ab);
    idle_cycles(3);
    chk("restart_first_addr", (m_addr.size() > 0) ? m_addr[0] : -1, 0);
    chk("restart_done_count", m_dones, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
